// File: rtl/eth_phy_10g_rx_hdr_lock_ml_pkg.sv
// Shared definitions for the 10G RX sync-header block-lock engine.
// Sync header codes, lane FSM states and a header classifier.
package eth_phy_10g_rx_hdr_lock_ml_pkg;

  localparam int HDR_W = 2;

  localparam logic [HDR_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic logic hdr_is_sync(
    input logic [HDR_W-1:0] h
  );
    return (h == SYNC_DATA) || (h == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_hdr_lock_lane.sv
// One lane of the 64b/66b block-lock engine: hunt/slip/locked FSM,
// window and bad-header counters, bitslip timer and header statistics.
module eth_phy_10g_rx_hdr_lock_lane
  import eth_phy_10g_rx_hdr_lock_ml_pkg::*;
#(
  parameter int LOCK_COUNT          = 64,
  parameter int WINDOW              = 1024,
  parameter int BAD_LIMIT           = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic [HDR_W-1:0] hdr,
  input  logic             hdr_valid,
  input  logic             force_unlock,
  input  logic             clear_counters,
  output logic             bitslip,
  output logic             block_lock,
  output logic             lock_event,
  output logic [7:0]       bad_hdr_count
);

  localparam int SLIP_LEN = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);
  localparam int TW = $clog2(SLIP_LEN + 1);

  lock_state_t   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [WW-1:0] win_q, win_n;
  logic [BW-1:0] bad_q, bad_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic          ev_q;
  logic [7:0]    stat_q;
  logic          hdr_good;
  logic          hdr_bad;

  assign hdr_good = hdr_valid && hdr_is_sync(hdr);
  assign hdr_bad  = hdr_valid && !hdr_is_sync(hdr);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    win_n   = win_q;
    bad_n   = bad_q;
    tmr_n   = tmr_q;
    if (force_unlock) begin
      state_n = ST_HUNT;
      cnt_n   = '0;
      win_n   = '0;
      bad_n   = '0;
      tmr_n   = '0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (hdr_bad) begin
            state_n = ST_SLIP;
            cnt_n   = '0;
            tmr_n   = '0;
          end else if (hdr_good) begin
            if (cnt_q == CW'(LOCK_COUNT - 1)) begin
              state_n = ST_LOCKED;
              cnt_n   = '0;
              win_n   = '0;
              bad_n   = '0;
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        ST_SLIP: begin
          if (tmr_q == TW'(SLIP_LEN - 1)) begin
            state_n = ST_HUNT;
            cnt_n   = '0;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + TW'(1);
          end
        end
        ST_LOCKED: begin
          // unlock takes precedence over a window rollover on the same beat
          if (hdr_bad && bad_q == BW'(BAD_LIMIT - 1)) begin
            state_n = ST_SLIP;
            tmr_n   = '0;
            win_n   = '0;
            bad_n   = '0;
          end else if (hdr_valid) begin
            if (win_q == WW'(WINDOW - 1)) begin
              win_n = '0;
              bad_n = '0;
            end else begin
              win_n = win_q + WW'(1);
              if (hdr_bad) bad_n = bad_q + BW'(1);
            end
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      tmr_q   <= '0;
      ev_q    <= 1'b0;
      stat_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      win_q   <= win_n;
      bad_q   <= bad_n;
      tmr_q   <= tmr_n;
      ev_q    <= (state_n == ST_LOCKED) ^ (state_q == ST_LOCKED);
      if (clear_counters) begin
        stat_q <= '0;
      end else if (hdr_bad && state_q != ST_SLIP && stat_q != 8'hFF) begin
        stat_q <= stat_q + 8'd1;
      end
    end
  end

  assign bitslip       = (state_q == ST_SLIP) &&
                         (tmr_q < TW'(BITSLIP_HIGH_CYCLES));
  assign block_lock    = (state_q == ST_LOCKED);
  assign lock_event    = ev_q;
  assign bad_hdr_count = stat_q;

endmodule

// File: rtl/eth_phy_10g_rx_hdr_lock_ml.sv
// Multi-lane 64b/66b sync-header block-lock engine for the 10G RX path.
// Replicates the per-lane engine and packs the lane results onto the ports.
module eth_phy_10g_rx_hdr_lock_ml
  import eth_phy_10g_rx_hdr_lock_ml_pkg::*;
#(
  parameter int LANES               = 1,
  parameter int HDR_WIDTH           = 2,
  parameter int LOCK_COUNT          = 64,
  parameter int WINDOW              = 1024,
  parameter int BAD_LIMIT           = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst_n,
  input  logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic [LANES-1:0]           serdes_rx_hdr_valid,
  input  logic                       cfg_force_unlock,
  input  logic                       cfg_clear_counters,
  output logic [LANES-1:0]           serdes_rx_bitslip,
  output logic [LANES-1:0]           rx_block_lock,
  output logic                       rx_all_lock,
  output logic [LANES-1:0]           rx_lock_event,
  output logic [LANES*8-1:0]         rx_bad_hdr_count
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    eth_phy_10g_rx_hdr_lock_lane #(
      .LOCK_COUNT          (LOCK_COUNT),
      .WINDOW              (WINDOW),
      .BAD_LIMIT           (BAD_LIMIT),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_lane (
      .rx_clk         (rx_clk),
      .rx_rst_n       (rx_rst_n),
      .hdr            (serdes_rx_hdr[i*HDR_WIDTH +: HDR_W]),
      .hdr_valid      (serdes_rx_hdr_valid[i]),
      .force_unlock   (cfg_force_unlock),
      .clear_counters (cfg_clear_counters),
      .bitslip        (serdes_rx_bitslip[i]),
      .block_lock     (rx_block_lock[i]),
      .lock_event     (rx_lock_event[i]),
      .bad_hdr_count  (rx_bad_hdr_count[i*8 +: 8])
    );
  end

  assign rx_all_lock = &rx_block_lock;

endmodule
